countdown_timer: RTL and testbench

Loadable down-counter that is the counterpart of the team's free-running T-flip-flop up-counter. It decrements from a software/switch-supplied start value at a prescaled rate, signals expiry with a one-cycle `done` pulse, and drives active-low seven-segment digit patterns for the board HEX displays. It sits between the switch/key inputs and the HEX outputs as a reusable timing primitive for lab designs.

---
 rtl/countdown_pkg.sv | 34 +++
 rtl/countdown_timer_if.sv | 34 +++
 rtl/hex7seg.sv | 11 +
 rtl/countdown_timer.sv | 120 ++++++++++++
 tb/tb_countdown_timer.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/countdown_pkg.sv
// Shared types and constants for countdown_timer: FSM state encoding and the
// active-low seven-segment patterns for hex digits 0-F.
package countdown_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StPause,
    StExpired
  } cd_state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Bit 0 = segment a ... bit 6 = segment g; 0 lights a segment.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle between the board inputs (master) and countdown_timer (slave).
interface countdown_timer_if #(
  parameter int unsigned WIDTH = 8
);

  logic                     load;
  logic [WIDTH-1:0]         start_val;
  logic                     enable;
  logic [WIDTH-1:0]         count;
  logic                     running;
  logic                     done;
  logic [7*(WIDTH/4)-1:0]   hex_out;

  modport master (
    output load,
    output start_val,
    output enable,
    input  count,
    input  running,
    input  done,
    input  hex_out
  );

  modport slave (
    input  load,
    input  start_val,
    input  enable,
    output count,
    output running,
    output done,
    output hex_out
  );

endinterface

// File: rtl/hex7seg.sv
// Nibble to active-low seven-segment pattern lookup.
module hex7seg
  import countdown_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/countdown_timer.sv
// Prescaled loadable down-counter with one-cycle done pulse and HEX display drive.
// Optional feature: COUNTDOWN_AUTO_RELOAD_EN restarts from the loaded value on expiry.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = 1
) (
  input  logic         clock,
  input  logic         clear_b,
  countdown_timer_if.slave bus
);

  localparam int unsigned PW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned DIGITS = WIDTH / 4;

  cd_state_t        state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             done_q, done_d;
  logic             tick;
  logic             reload_ok;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
  assign reload_ok = (reload_q != '0);
`else
  assign reload_ok = 1'b0;
`endif

  assign tick = (presc_q == PW'(DIV - 1));

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    presc_d = presc_q;
    done_d  = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    if (bus.load) begin
      count_d = bus.start_val;
      presc_d = '0;
      state_d = StIdle;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_d = bus.start_val;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.enable && (count_q != '0)) state_d = StRun;
        end
        StRun: begin
          // Pausing wins over a tick landing on the same edge.
          if (!bus.enable) begin
            state_d = StPause;
          end else if (tick) begin
            presc_d = '0;
            if (count_q == '0) begin
              // Only reachable with auto-reload: restart one tick after hitting 0.
`ifdef COUNTDOWN_AUTO_RELOAD_EN
              count_d = reload_q;
`endif
            end else begin
              count_d = count_q - WIDTH'(1);
              if (count_q == WIDTH'(1)) begin
                done_d = 1'b1;
                if (!reload_ok) state_d = StExpired;
              end
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        StPause: begin
          if (bus.enable) state_d = StRun;
        end
        StExpired: begin
          state_d = StExpired;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock or negedge clear_b) begin
    if (!clear_b) begin
      state_q <= StIdle;
      count_q <= '0;
      presc_q <= '0;
      done_q  <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      presc_q <= presc_d;
      done_q  <= done_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  logic [7*DIGITS-1:0] hex;

  for (genvar k = 0; k < DIGITS; k++) begin : g_hex
    hex7seg u_hex7seg (
      .nibble (count_q[4*k +: 4]),
      .seg    (hex[7*k +: 7])
    );
  end

  assign bus.count   = count_q;
  assign bus.running = (state_q == StRun);
  assign bus.done    = done_q;
  assign bus.hex_out = hex;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: one DIV=1 and one DIV=4 instance on a shared clock/reset.
module tb_countdown_timer;

  logic clock = 1'b0;
  logic clear_b = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clock = ~clock;

  countdown_timer_if #(.WIDTH(8)) if1 ();
  countdown_timer_if #(.WIDTH(8)) if4 ();

  countdown_timer #(.WIDTH(8), .DIV(1)) u_div1 (
    .clock   (clock),
    .clear_b (clear_b),
    .bus     (if1)
  );

  countdown_timer #(.WIDTH(8), .DIV(4)) u_div4 (
    .clock   (clock),
    .clear_b (clear_b),
    .bus     (if4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    if1.load = 0; if1.start_val = '0; if1.enable = 0;
    if4.load = 0; if4.start_val = '0; if4.enable = 0;
    #2;
    chk("rst_count", {24'd0, if1.count}, 32'h0);
    chk("rst_running", {31'd0, if1.running}, 32'h0);
    chk("rst_done", {31'd0, if1.done}, 32'h0);
    chk("rst_hex", {18'd0, if1.hex_out}, {18'd0, 14'b1000000_1000000});
    step(1);
    clear_b = 1'b1;

    // DIV=1, load 3, enable high.
    if1.load = 1; if1.start_val = 8'd3;
    step(1);
    chk("d1_load", {24'd0, if1.count}, 32'd3);
    if1.load = 0; if1.enable = 1;
    step(1);
    chk("d1_e1_cnt", {24'd0, if1.count}, 32'd3);
    chk("d1_e1_run", {31'd0, if1.running}, 32'd1);
    step(1);
    chk("d1_e2_cnt", {24'd0, if1.count}, 32'd2);
    step(1);
    chk("d1_e3_cnt", {24'd0, if1.count}, 32'd1);
    chk("d1_e3_done", {31'd0, if1.done}, 32'd0);
    step(1);
    chk("d1_e4_cnt", {24'd0, if1.count}, 32'd0);
    chk("d1_e4_done", {31'd0, if1.done}, 32'd1);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    chk("d1_e4_run", {31'd0, if1.running}, 32'd1);
    step(1);
    chk("d1_e5_done", {31'd0, if1.done}, 32'd0);
    chk("ar_e5_cnt", {24'd0, if1.count}, 32'd3);
`else
    chk("d1_e4_run", {31'd0, if1.running}, 32'd0);
    step(1);
    chk("d1_e5_done", {31'd0, if1.done}, 32'd0);
    step(3);
    chk("d1_exp_cnt", {24'd0, if1.count}, 32'd0);
    chk("d1_exp_run", {31'd0, if1.running}, 32'd0);
    chk("d1_exp_done", {31'd0, if1.done}, 32'd0);
`endif

    // Load landing on the final tick wins; no done pulse.
    if1.load = 1; if1.start_val = 8'd1;
    step(1);
    if1.load = 0;
    step(1);
    chk("lt_run", {31'd0, if1.running}, 32'd1);
    if1.load = 1; if1.start_val = 8'd7;
    step(1);
    chk("lt_cnt", {24'd0, if1.count}, 32'd7);
    chk("lt_done", {31'd0, if1.done}, 32'd0);
    chk("lt_run2", {31'd0, if1.running}, 32'd0);

    // Load zero with enable high: stays idle.
    if1.start_val = 8'd0;
    step(1);
    if1.load = 0;
    step(3);
    chk("z_cnt", {24'd0, if1.count}, 32'd0);
    chk("z_run", {31'd0, if1.running}, 32'd0);
    chk("z_done", {31'd0, if1.done}, 32'd0);

    // Hex patterns for 0xF1.
    if1.enable = 0; if1.load = 1; if1.start_val = 8'hF1;
    step(1);
    if1.load = 0;
    chk("hex_hi", {25'd0, if1.hex_out[13:7]}, {25'd0, 7'b0001110});
    chk("hex_lo", {25'd0, if1.hex_out[6:0]}, {25'd0, 7'b1111001});

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    // Auto-reload, load 2: 2,1,0,2,1,0 with done at each 0.
    if1.load = 1; if1.start_val = 8'd2;
    step(1);
    if1.load = 0; if1.enable = 1;
    step(1);
    chk("ar_1", {24'd0, if1.count}, 32'd2);
    step(1);
    chk("ar_2", {24'd0, if1.count}, 32'd1);
    step(1);
    chk("ar_3", {24'd0, if1.count}, 32'd0);
    chk("ar_3d", {31'd0, if1.done}, 32'd1);
    step(1);
    chk("ar_4", {24'd0, if1.count}, 32'd2);
    chk("ar_4d", {31'd0, if1.done}, 32'd0);
    step(2);
    chk("ar_6", {24'd0, if1.count}, 32'd0);
    chk("ar_6d", {31'd0, if1.done}, 32'd1);
    if1.enable = 0;
`endif

    // DIV=4, load 2.
    if4.load = 1; if4.start_val = 8'd2;
    step(1);
    if4.load = 0; if4.enable = 1;
    step(4);
    chk("d4_e4_cnt", {24'd0, if4.count}, 32'd2);
    step(1);
    chk("d4_e5_cnt", {24'd0, if4.count}, 32'd1);
    step(3);
    chk("d4_e8_cnt", {24'd0, if4.count}, 32'd1);
    chk("d4_e8_done", {31'd0, if4.done}, 32'd0);
    step(1);
    chk("d4_e9_cnt", {24'd0, if4.count}, 32'd0);
    chk("d4_e9_done", {31'd0, if4.done}, 32'd1);
    step(1);
    chk("d4_e10_done", {31'd0, if4.done}, 32'd0);

    // Pause with prescaler phase held at 2.
    if4.load = 1; if4.start_val = 8'd5;
    step(1);
    if4.load = 0;
    step(11);
    chk("p_cnt3", {24'd0, if4.count}, 32'd3);
    if4.enable = 0;
    step(10);
    chk("p_hold_cnt", {24'd0, if4.count}, 32'd3);
    chk("p_hold_run", {31'd0, if4.running}, 32'd0);
    if4.enable = 1;
    step(1);
    chk("p_res_run", {31'd0, if4.running}, 32'd1);
    step(1);
    chk("p_res1_cnt", {24'd0, if4.count}, 32'd3);
    step(1);
    chk("p_res2_cnt", {24'd0, if4.count}, 32'd2);

    // Asynchronous reset mid-RUN at 0x2A.
    if4.load = 1; if4.start_val = 8'h2A;
    step(1);
    if4.load = 0;
    step(2);
    chk("mr_run", {31'd0, if4.running}, 32'd1);
    clear_b = 1'b0;
    #1;
    chk("mr_cnt", {24'd0, if4.count}, 32'd0);
    chk("mr_running", {31'd0, if4.running}, 32'd0);
    chk("mr_done", {31'd0, if4.done}, 32'd0);
    chk("mr_hex", {18'd0, if4.hex_out}, {18'd0, 14'b1000000_1000000});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
